// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcode type, opcode constants and request record.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 32;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_AND = 3'b010;
    localparam alu_op_t OP_OR  = 3'b011;
    localparam alu_op_t OP_SRL = 3'b100;
    localparam alu_op_t OP_SRA = 3'b101;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_t           op;
    } alu_req_t;

    // Opcodes 110/111 have no ALU function assigned.
    function automatic logic op_is_illegal(input alu_op_t op);
        return op[2] & op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_fifo
// Description : Request FIFO with unreset storage; head is always visible.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_req_t wdata,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output alu_req_t head
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    alu_req_t      r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_queue
// Description : Buffers ALU requests, presents the FIFO head to the ALU and
//               captures its result into a valid/ready output slot.
//               Optional build macro: ALU_OP_CHECK_EN (adds res_err).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [2:0]        res_op
`ifdef ALU_OP_CHECK_EN
    ,
    output logic              res_err
`endif
);

    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_issue;
    logic     w_slot_free;
    alu_req_t w_wdata;
    alu_req_t w_head;

    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    alu_op_t           r_res_op;

    // No full-bypass: a pop in the same cycle does not reopen a full FIFO.
    assign req_ready   = !w_full;
    assign w_push      = req_valid && !w_full;
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_issue     = !w_empty && w_slot_free;
    assign w_wdata     = '{a: req_a, b: req_b, op: req_op};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (w_wdata),
        .pop   (w_issue),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign alu_a  = w_head.a;
    assign alu_b  = w_head.b;
    assign alu_op = w_head.op;

`ifdef ALU_OP_CHECK_EN
    logic r_res_err;
    assign res_err = r_res_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_err <= 1'b0;
        end else if (w_issue) begin
            r_res_err <= op_is_illegal(alu_op);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else if (w_issue) begin
            r_res_valid <= 1'b1;
            r_res_op    <= alu_op;
`ifdef ALU_OP_CHECK_EN
            r_res_data  <= op_is_illegal(alu_op) ? '0 : alu_c;
`else
            r_res_data  <= alu_c;
`endif
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;

endmodule
`default_nettype wire
